mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port RV64 memory between the instruction-fetch requester (read-only) and the load/store requester (read/write).
- Fixed data-over-fetch priority with a starvation guard.
- At most one transaction outstanding.
- Handles fetch flush on jump so stale instructions are never delivered.
- Sits between the fetch stage, the memory stage and the memory array.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width (fetch uses low 32 bits)
MEM_LAT, 1, cycles from memory enable to read data valid; legal range 1..8
STARVE_MAX, 4, consecutive lost fetch arbitrations before fetch is forced to win; must be ≥1

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous reset, active-low
i_f_req  in  1  fetch request; hold with i_f_addr stable until o_f_gnt
i_f_addr  in  ADDR_W  fetch address
i_f_flush  in  1  jump taken; discard any outstanding fetch response
o_f_gnt  out  1  fetch accepted (one cycle)
o_f_rvalid  out  1  fetch data valid (one cycle)
o_f_rdata  out  32  instruction
i_d_req  in  1  data request; hold with address/data until o_d_gnt
i_d_we  in  1  1 = store
i_d_addr  in  ADDR_W  data address
i_d_wdata  in  DATA_W  store data
i_d_wstrb  in  DATA_W/8  byte strobes
o_d_gnt  out  1  data accepted
o_d_rvalid  out  1  load data valid, or store acknowledge
o_d_rdata  out  DATA_W  load data (0 on store ack)
o_mem_en  out  1  memory access this cycle
o_mem_we  out  1  write
o_mem_addr  out  ADDR_W  address
o_mem_wdata  out  DATA_W  write data
o_mem_wstrb  out  DATA_W/8  strobes
i_mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after the o_mem_en cycle

Behaviour:
- FSM states: IDLE and BUSY. Registered state: owner (F/D), a latency counter, a flush-kill flag and starve_cnt.
- Reset (async, i_rst_n low):
  - state=IDLE, counters=0, kill=0.
  - All gnt, rvalid and o_mem_* outputs are 0; gnts are gated low while reset is asserted.
  - Reset mid-transaction drops the response silently.
- IDLE, cycle T:
  - If any request is present, grant exactly one. Grant, o_mem_* and the mux select are combinational from the inputs.
  - Move to BUSY with lat_cnt=MEM_LAT and owner recorded.
- Selection rule:
  - Data wins unless only fetch requests, or starve_cnt==STARVE_MAX.
  - starve_cnt increments when both request and data wins. It clears whenever fetch is granted.
- BUSY:
  - No grants and o_mem_en=0. lat_cnt decrements each cycle.
  - In the cycle where lat_cnt==1 (cycle T+MEM_LAT), the owner's rvalid=1 and rdata=i_mem_rdata (fetch takes bits [31:0]). Return to IDLE next cycle.
  - Throughput: one transaction per MEM_LAT+1 cycles.
- Flush:
  - i_f_flush in any cycle while owner=F in BUSY sets kill. The grant cycle also counts if fetch was granted that cycle.
  - When kill is set, o_f_rvalid is suppressed for that transaction; kill clears on return to IDLE.
  - Flush in IDLE or with owner=D has no effect.
  - Flush in the rvalid cycle itself suppresses that rvalid.
- Store: memory writes at cycle T. o_d_rvalid pulses at T+MEM_LAT with o_d_rdata=0.
- A request dropped before grant is a protocol violation; the arbiter behaviour is undefined only in its next grant choice, never its state.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined:
  - Adds 32-bit outputs o_perf_f_stall (cycles i_f_req high without o_f_gnt) and o_perf_flush_drop (killed fetch responses).
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined: these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg contains:
  - state enum {ST_IDLE, ST_BUSY}
  - owner enum {OWN_F, OWN_D}
  - MEM_LAT_MAX=8
  - lat counter width derived from MEM_LAT_MAX
- One sub-module, arb_starve_sel: combinational winner select plus the registered starve_cnt; inputs both reqs and an idle flag; output winner/grant pair.

Test Plan:
- MEM_LAT=1, fetch only, addr 0x8 → o_f_gnt at T, o_mem_en=1/addr=0x8 at T, o_f_rvalid at T+1 with rdata=mem[0x8]; next grant possible at T+2.
- Both requesters held high continuously, STARVE_MAX=4 → grant order D,D,D,D,F, repeating; o_f_gnt every 5th grant.
- Store 0xDEADBEEF strobe 0x0F to 0x10, then load 0x10 → o_d_rvalid ack with rdata=0, then load returns 0x00000000DEADBEEF (memory pre-zeroed).
- MEM_LAT=3, fetch granted at T, i_f_flush at T+2 → no o_f_rvalid; IDLE at T+4; a new fetch to 0x20 completes normally.
- i_rst_n low at T+1 of a MEM_LAT=3 data read → all outputs 0 immediately, no o_d_rvalid; after release the pending i_d_req is granted on the first IDLE cycle.
- With MEM_ARB_PERF_EN, fetch blocked by data for 3 cycles then flushed once → o_perf_f_stall=3, o_perf_flush_drop=1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;
    typedef enum logic {OWN_F, OWN_D} owner_t;

    localparam int unsigned MEM_LAT_MAX = 8;
    localparam int unsigned LAT_W       = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/arb_starve_sel.sv
// Fetch/data winner selection: data has priority unless fetch has lost
// STARVE_MAX consecutive contested arbitrations.
module arb_starve_sel
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   f_req,
    input  logic   d_req,
    input  logic   idle,
    output owner_t winner,
    output logic   f_gnt,
    output logic   d_gnt
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_cnt;
    logic          force_f;

    // Grants are gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        force_f = (starve_cnt == SW'(STARVE_MAX));
        winner  = OWN_D;
        f_gnt   = 1'b0;
        d_gnt   = 1'b0;
        if (idle && rst_n) begin
            if (f_req && (!d_req || force_f)) begin
                f_gnt  = 1'b1;
                winner = OWN_F;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (f_gnt) begin
            starve_cnt <= '0;
        end else if (d_gnt && f_req) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, one
// transaction outstanding. Optional perf counters: define MEM_ARB_PERF_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_f_req,
    input  logic [ADDR_W-1:0]   i_f_addr,
    input  logic                i_f_flush,
    output logic                o_f_gnt,
    output logic                o_f_rvalid,
    output logic [31:0]         o_f_rdata,
    input  logic                i_d_req,
    input  logic                i_d_we,
    input  logic [ADDR_W-1:0]   i_d_addr,
    input  logic [DATA_W-1:0]   i_d_wdata,
    input  logic [DATA_W/8-1:0] i_d_wstrb,
    output logic                o_d_gnt,
    output logic                o_d_rvalid,
    output logic [DATA_W-1:0]   o_d_rdata,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]         o_perf_f_stall,
    output logic [31:0]         o_perf_flush_drop,
`endif
    output logic                o_mem_en,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_wstrb,
    input  logic [DATA_W-1:0]   i_mem_rdata
);

    state_t             state, state_nxt;
    owner_t             owner, winner;
    logic [LAT_W-1:0]   lat_cnt;
    logic               kill;
    logic               st_we;
    logic               idle, last, grant, f_gnt, d_gnt;

    assign idle  = (state == ST_IDLE);
    assign last  = (state == ST_BUSY) && (lat_cnt == LAT_W'(1));
    assign grant = f_gnt | d_gnt;

    arb_starve_sel #(.STARVE_MAX(STARVE_MAX)) u_sel (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .f_req  (i_f_req),
        .d_req  (i_d_req),
        .idle   (idle),
        .winner (winner),
        .f_gnt  (f_gnt),
        .d_gnt  (d_gnt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant) state_nxt = ST_BUSY;
            ST_BUSY: if (last)  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            owner   <= OWN_F;
            lat_cnt <= '0;
            kill    <= 1'b0;
            st_we   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner   <= winner;
                lat_cnt <= LAT_W'(MEM_LAT);
                st_we   <= d_gnt & i_d_we;
                kill    <= f_gnt & i_f_flush;
            end else if (state == ST_BUSY) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
                if (last) begin
                    kill <= 1'b0;
                end else if (owner == OWN_F && i_f_flush) begin
                    kill <= 1'b1;
                end
            end
        end
    end

    // A flush in the response cycle itself must still hide the stale instruction.
    always_comb begin
        o_f_gnt     = f_gnt;
        o_d_gnt     = d_gnt;
        o_mem_en    = grant;
        o_mem_we    = d_gnt & i_d_we;
        o_mem_addr  = d_gnt ? i_d_addr : (f_gnt ? i_f_addr : '0);
        o_mem_wdata = o_mem_we ? i_d_wdata : '0;
        o_mem_wstrb = o_mem_we ? i_d_wstrb : '0;
        o_f_rvalid  = last && (owner == OWN_F) && !kill && !i_f_flush;
        o_f_rdata   = o_f_rvalid ? i_mem_rdata[31:0] : '0;
        o_d_rvalid  = last && (owner == OWN_D);
        o_d_rdata   = (o_d_rvalid && !st_we) ? i_mem_rdata : '0;
    end

`ifdef MEM_ARB_PERF_EN
    logic f_drop;
    assign f_drop = last && (owner == OWN_F) && (kill || i_f_flush);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_perf_f_stall    <= '0;
            o_perf_flush_drop <= '0;
        end else begin
            if (i_f_req && !f_gnt && o_perf_f_stall != '1)
                o_perf_f_stall <= o_perf_f_stall + 32'd1;
            if (f_drop && o_perf_flush_drop != '1)
                o_perf_flush_drop <= o_perf_flush_drop + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: timestamp-based transaction model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_port_arbiter;

    localparam int ML = 3;
    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_req = 1'b0, f_flush = 1'b0;
    logic [63:0] f_addr = '0;
    logic        f_gnt, f_rvalid;
    logic [31:0] f_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [63:0] d_addr = '0, d_wdata = '0;
    logic [7:0]  d_wstrb = '0;
    logic        d_gnt, d_rvalid;
    logic [63:0] d_rdata;
    logic        mem_en, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wstrb;
    logic [63:0] mem_rdata = '0;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_f_stall, perf_flush_drop;
`endif

    mem_port_arbiter #(
        .ADDR_W(64), .DATA_W(64), .MEM_LAT(ML), .STARVE_MAX(SM)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_f_req(f_req), .i_f_addr(f_addr), .i_f_flush(f_flush),
        .o_f_gnt(f_gnt), .o_f_rvalid(f_rvalid), .o_f_rdata(f_rdata),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr),
        .i_d_wdata(d_wdata), .i_d_wstrb(d_wstrb),
        .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
`ifdef MEM_ARB_PERF_EN
        .o_perf_f_stall(perf_f_stall), .o_perf_flush_drop(perf_flush_drop),
`endif
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb),
        .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Memory array environment: responds to the DUT's memory port MEM_LAT cycles later.
    logic [63:0] env_mem [16];
    logic [63:0] due_q [int];
    int          env_idx;

    always @(negedge clk) begin
        if (rst_n && mem_en) begin
            env_idx = int'(mem_addr[6:3]);
            due_q[cyc + ML] = mem_we ? {$urandom, $urandom} : env_mem[env_idx];
            if (mem_we)
                for (int b = 0; b < 8; b++)
                    if (mem_wstrb[b]) env_mem[env_idx][b*8 +: 8] = mem_wdata[b*8 +: 8];
        end
    end

    always @(posedge clk) begin
        #2;
        if (due_q.exists(cyc)) begin
            mem_rdata = due_q[cyc];
            due_q.delete(cyc);
        end else begin
            mem_rdata = {$urandom, $urandom};
        end
    end

    // Reference model: arbiter is free again MEM_LAT+1 cycles after a grant,
    // the response lands exactly MEM_LAT cycles after it.
    logic [63:0] ref_mem [16];
    int          free_at = 0, t_start = 0, m_starve = 0, cm_idx;
    bit          m_own_f = 1'b0, m_kill = 1'b0, m_we = 1'b0;
    logic [63:0] m_rdata = '0;
    longint      m_stall = 0, m_drop = 0;
    bit          cm_idle, e_fg, e_dg, resp, e_frv, e_drv;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_f_gnt", 64'(f_gnt), 64'd0);
            check("rst_d_gnt", 64'(d_gnt), 64'd0);
            check("rst_mem_en", 64'(mem_en), 64'd0);
            check("rst_mem_we", 64'(mem_we), 64'd0);
            check("rst_mem_addr", mem_addr, 64'd0);
            check("rst_mem_wdata", mem_wdata, 64'd0);
            check("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
            check("rst_f_rvalid", 64'(f_rvalid), 64'd0);
            check("rst_d_rvalid", 64'(d_rvalid), 64'd0);
            free_at  = cyc + 1;
            m_kill   = 1'b0;
            m_starve = 0;
            m_stall  = 0;
            m_drop   = 0;
        end else begin
            cm_idle = (cyc >= free_at);
            e_fg    = cm_idle && f_req && (!d_req || m_starve == SM);
            e_dg    = cm_idle && d_req && !e_fg;
            check("f_gnt", 64'(f_gnt), 64'(e_fg));
            check("d_gnt", 64'(d_gnt), 64'(e_dg));
            check("mem_en", 64'(mem_en), 64'(e_fg || e_dg));
            if (e_fg) begin
                check("mem_addr_f", mem_addr, f_addr);
                check("mem_we_f", 64'(mem_we), 64'd0);
            end
            if (e_dg) begin
                check("mem_addr_d", mem_addr, d_addr);
                check("mem_we_d", 64'(mem_we), 64'(d_we));
                if (d_we) begin
                    check("mem_wdata", mem_wdata, d_wdata);
                    check("mem_wstrb", 64'(mem_wstrb), 64'(d_wstrb));
                end
            end
            resp  = !cm_idle && (cyc == t_start + ML);
            e_frv = resp && m_own_f && !m_kill && !f_flush;
            e_drv = resp && !m_own_f;
            check("f_rvalid", 64'(f_rvalid), 64'(e_frv));
            check("d_rvalid", 64'(d_rvalid), 64'(e_drv));
            if (e_frv) check("f_rdata", 64'(f_rdata), 64'(m_rdata[31:0]));
            if (e_drv) check("d_rdata", d_rdata, m_we ? 64'd0 : m_rdata);
            if (f_req && !e_fg) m_stall++;
            if (resp && m_own_f && !e_frv) m_drop++;

            if (!cm_idle && m_own_f && f_flush) m_kill = 1'b1;
            if (e_fg || e_dg) begin
                t_start = cyc;
                free_at = cyc + ML + 1;
                m_own_f = e_fg;
                m_kill  = e_fg && f_flush;
                m_we    = e_dg && d_we;
                cm_idx  = e_fg ? int'(f_addr[6:3]) : int'(d_addr[6:3]);
                m_rdata = ref_mem[cm_idx];
                if (m_we)
                    for (int b = 0; b < 8; b++)
                        if (d_wstrb[b]) ref_mem[cm_idx][b*8 +: 8] = d_wdata[b*8 +: 8];
                if (e_fg) m_starve = 0;
                else if (f_req) m_starve++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        f_req   = 1'b0;
        d_req   = 1'b0;
        f_flush = 1'b0;
        repeat (ML + 2) step();
    endtask

    // which: 0 f_gnt, 1 d_gnt, 2 f_rvalid, 3 d_rvalid; bounded wait
    task automatic wait_sig(input int which, input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            case (which)
                0:       seen = f_gnt;
                1:       seen = d_gnt;
                2:       seen = f_rvalid;
                default: seen = d_rvalid;
            endcase
        end
        check(name, 64'(seen), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    int    t0;
    bit    fg, dg;
    string seq;

    initial begin
        for (int i = 0; i < 16; i++) begin
            env_mem[i] = '0;
            ref_mem[i] = '0;
        end
        env_mem[1] = 64'h1122334455667788;
        ref_mem[1] = 64'h1122334455667788;

        // Requests present during reset must not be granted.
        f_req = 1'b1; d_req = 1'b1; f_addr = 64'h8; d_addr = 64'h8;
        repeat (3) @(negedge clk);
        check("a0_rst_gated", {61'd0, f_gnt, d_gnt, mem_en}, 64'd0);
        step();
        f_req = 1'b0; d_req = 1'b0; rst_n = 1'b1;
        step();

        // Fetch only from 0x8.
        f_req = 1'b1; f_addr = 64'h8;
        wait_sig(0, "a_f_gnt");
        t0 = cyc;
        check("a_mem_addr", mem_addr, 64'h8);
        step();
        f_req = 1'b0;
        wait_sig(2, "a_f_rvalid");
        check("a_lat", 64'(cyc - t0), 64'(ML));
        check("a_rdata", 64'(f_rdata), 64'h55667788);
        step();
        f_req = 1'b1;
        @(negedge clk);
        check("a_next_gnt", 64'(f_gnt), 64'd1);
        check("a_next_gap", 64'(cyc - t0), 64'(ML + 1));
        step();
        drain();

        // Store with partial strobe, then load back.
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h10;
        d_wdata = 64'hDEADBEEF; d_wstrb = 8'h0F;
        wait_sig(1, "b_st_gnt");
        step();
        d_req = 1'b0;
        wait_sig(3, "b_st_ack");
        check("b_st_rdata", d_rdata, 64'd0);
        step();
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h10;
        wait_sig(1, "b_ld_gnt");
        step();
        d_req = 1'b0;
        wait_sig(3, "b_ld_rvalid");
        check("b_ld_rdata", d_rdata, 64'h00000000DEADBEEF);
        step();
        drain();

        // Both requesters held high: starvation guard lets fetch through every 5th grant.
        f_req = 1'b1; f_addr = 64'h18;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h20;
        seq = "";
        for (int g = 0; g < 10; g++) begin
            fg = 1'b0; dg = 1'b0;
            for (int k = 0; k < 2 * ML + 4 && !(fg || dg); k++) begin
                @(negedge clk);
                fg = f_gnt;
                dg = d_gnt;
            end
            seq = {seq, fg ? "F" : (dg ? "D" : "-")};
            step();
        end
        checks++;
        if (seq != "DDDDFDDDDF") begin
            failures++;
            $display("FAIL c_grant_order got=%s want=DDDDFDDDDF", seq);
        end
        drain();

        // Flush two cycles after a fetch grant.
        f_req = 1'b1; f_addr = 64'h28;
        wait_sig(0, "d_f_gnt");
        step();
        f_req = 1'b0;
        step();
        f_flush = 1'b1;
        step();
        f_flush = 1'b0;
        @(negedge clk);
        check("d_no_rvalid", 64'(f_rvalid), 64'd0);
        step();
        f_req = 1'b1; f_addr = 64'h20;
        @(negedge clk);
        check("d_idle_gnt", 64'(f_gnt), 64'd1);
        step();
        f_req = 1'b0;
        wait_sig(2, "d_new_rvalid");
        check("d_new_rdata", 64'(f_rdata), 64'd0);
        step();
        drain();

        // Reset during a data read; the still-pending request wins right after release.
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h10;
        wait_sig(1, "e_d_gnt");
        step();
        rst_n = 1'b0;
        @(negedge clk);
        check("e_rst_ctrl", {59'd0, f_gnt, d_gnt, mem_en, f_rvalid, d_rvalid}, 64'd0);
        check("e_rst_addr", mem_addr, 64'd0);
        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk);
        check("e_regrant", 64'(d_gnt), 64'd1);
        step();
        d_req = 1'b0;
        wait_sig(3, "e_rvalid");
        check("e_rdata", d_rdata, 64'h00000000DEADBEEF);
        step();
        drain();

        // Randomized traffic obeying the hold-until-grant protocol.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            fg = f_gnt;
            dg = d_gnt;
            step();
            if (fg || !f_req) begin
                f_req  = ($urandom_range(0, 99) < 60);
                f_addr = 64'($urandom_range(0, 31)) << 2;
            end
            if (dg || !d_req) begin
                d_req   = ($urandom_range(0, 99) < 55);
                d_we    = ($urandom_range(0, 1) == 1);
                d_addr  = 64'($urandom_range(0, 15)) << 3;
                d_wdata = {$urandom, $urandom};
                d_wstrb = 8'($urandom_range(0, 255));
            end
            f_flush = ($urandom_range(0, 99) < 8);
        end
        drain();

`ifdef MEM_ARB_PERF_EN
        @(negedge clk);
        check("perf_f_stall", 64'(perf_f_stall), 64'(m_stall));
        check("perf_flush_drop", 64'(perf_flush_drop), 64'(m_drop));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
